// File: rtl/cpu_pkg.sv
// Shared definitions for the mini CPU: memory geometry, loader framing and loader state encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned IMEM_DEPTH = 16;
    localparam int unsigned INSTR_W    = 8;
    localparam int unsigned CNT_W      = ADDR_W + 1;

    localparam logic [DATA_W-1:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN  = 3'd1,
        LD_DATA = 3'd2,
        LD_CSUM = 3'd3,
        LD_DONE = 3'd4,
        LD_ERR  = 3'd5
    } loader_state_t;

    // Registered instruction-memory write port
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } imem_wr_t;

    // Registered loader status levels
    typedef struct packed {
        logic cpu_reset;
        logic load_done;
        logic load_err;
    } loader_status_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-wide valid/ready program stream into the loader.
interface prog_loader_if
    import cpu_pkg::*;
();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory loader: parses SYNC/LEN/data/CSUM frames, writes the payload
// into instruction memory and holds the CPU in reset until a frame verifies.
module prog_loader
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    prog_loader_if.slave      strm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);

    loader_state_t        state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     len_q, len_d;
    logic [DATA_W-1:0]    sum_q, sum_d;
    imem_wr_t             wr_q, wr_d;
    loader_status_t       stat_q, stat_d;
    logic                 ready_q;

    logic                 xfer;
    logic                 len_ok;
    logic [CNT_W-1:0]     cnt_inc;
    logic [DATA_W-1:0]    sum_add;

    assign strm.in_ready = ready_q;
    assign imem_we       = wr_q.we;
    assign imem_addr     = wr_q.addr;
    assign imem_wdata    = wr_q.wdata;
    assign cpu_reset     = stat_q.cpu_reset;
    assign load_done     = stat_q.load_done;
    assign load_err      = stat_q.load_err;

    // Next-state, datapath and registered-output decode for each accepted byte
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sum_d   = sum_q;
        wr_d    = '{we: 1'b0, addr: wr_q.addr, wdata: wr_q.wdata};
        stat_d  = stat_q;

        xfer    = strm.in_valid & ready_q;
        len_ok  = (strm.in_data != '0) && (strm.in_data <= DATA_W'(IMEM_DEPTH));
        cnt_inc = cnt_q + CNT_W'(1);
        sum_add = sum_q + strm.in_data;

        if (xfer) begin
            case (state_q)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (strm.in_data == LOADER_SYNC) begin
                        state_d = LD_LEN;
                        stat_d  = '{cpu_reset: 1'b1, load_done: 1'b0, load_err: 1'b0};
                    end
                end
                LD_LEN: begin
                    if (len_ok) begin
                        len_d   = CNT_W'(strm.in_data);
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = LD_DATA;
                    end else begin
                        state_d = LD_ERR;
                        stat_d  = '{cpu_reset: 1'b1, load_done: 1'b0, load_err: 1'b1};
                    end
                end
                LD_DATA: begin
                    wr_d  = '{we: 1'b1, addr: cnt_q[ADDR_W-1:0], wdata: strm.in_data};
                    sum_d = sum_add;
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = LD_CSUM;
                    end
                end
                LD_CSUM: begin
                    if (sum_add == '0) begin
                        state_d = LD_DONE;
                        stat_d  = '{cpu_reset: 1'b0, load_done: 1'b1, load_err: 1'b0};
                    end else begin
                        state_d = LD_ERR;
                        stat_d  = '{cpu_reset: 1'b1, load_done: 1'b0, load_err: 1'b1};
                    end
                end
                default: begin
                    state_d = LD_IDLE;
                end
            endcase
        end
    end

    // State, datapath and output registers; reset drops any pending write
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LD_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            wr_q    <= '0;
            stat_q  <= '{cpu_reset: 1'b1, load_done: 1'b0, load_err: 1'b0};
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            wr_q    <= wr_d;
            stat_q  <= stat_d;
            ready_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frame-level reference model feeds expected
// writes and status levels; a negedge monitor compares everything the DUT shows.
module tb_prog_loader;
    import cpu_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              load_err;

    prog_loader_if strm ();

    prog_loader dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .strm       (strm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    // Reference-model expectations
    logic        exp_ready     = 1'b0;
    logic        exp_cpu_reset = 1'b1;
    logic        exp_done      = 1'b0;
    logic        exp_err       = 1'b0;
    logic [11:0] wr_q[$];
    logic [7:0]  fdat[16];
    bit          finish_req    = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    // Monitor: compare status levels every cycle and pop one expected write per strobe
    always @(negedge clk) begin : monitor
        logic [11:0] w;
        vectors++;
        if ({strm.in_ready, cpu_reset, load_done, load_err} !==
            {exp_ready, exp_cpu_reset, exp_done, exp_err}) begin
            miscompares++;
            $display("FAIL status @%0t: got rdy=%b rst=%b done=%b err=%b, want rdy=%b rst=%b done=%b err=%b",
                     $time, strm.in_ready, cpu_reset, load_done, load_err,
                     exp_ready, exp_cpu_reset, exp_done, exp_err);
        end
        if (!reset_n) begin
            vectors++;
            if ({imem_we, imem_addr, imem_wdata} !== 13'd0) begin
                miscompares++;
                $display("FAIL reset_port @%0t: got we=%b addr=%h wdata=%h, want all zero",
                         $time, imem_we, imem_addr, imem_wdata);
            end
        end else if (imem_we === 1'b1) begin
            vectors++;
            if (wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL write @%0t: got unexpected write addr=%h data=%h, want none",
                         $time, imem_addr, imem_wdata);
            end else begin
                w = wr_q.pop_front();
                if ({imem_addr, imem_wdata} !== w) begin
                    miscompares++;
                    $display("FAIL write @%0t: got addr=%h data=%h, want addr=%h data=%h",
                             $time, imem_addr, imem_wdata, w[11:8], w[7:0]);
                end
            end
        end else if (imem_we !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL we_x @%0t: got we=%b, want 0 or 1", $time, imem_we);
        end
        if (finish_req) begin
            vectors++;
            if (wr_q.size() != 0) begin
                miscompares++;
                $display("FAIL pending_writes: got %0d writes missing, want 0", wr_q.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
            $finish;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_status(input logic r, input logic d, input logic e);
        exp_cpu_reset = r;
        exp_done      = d;
        exp_err       = e;
    endtask

    // One stream transfer, preceded by a random gap of idle cycles
    task automatic send_byte(input logic [7:0] b);
        idle_cycles($urandom_range(0, 2));
        strm.in_valid = 1'b1;
        strm.in_data  = b;
        @(posedge clk);
        #1;
        strm.in_valid = 1'b0;
        strm.in_data  = 8'($urandom);
    endtask

    function automatic logic [7:0] good_csum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(fdat[i]);
        return 8'((256 - (s % 256)) % 256);
    endfunction

    // Full frame of n data bytes taken from fdat; outcome from the checksum rule
    task automatic send_frame(input int n, input logic [7:0] csum);
        int s = 0;
        send_byte(LOADER_SYNC);
        set_status(1'b1, 1'b0, 1'b0);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(fdat[i]);
            wr_q.push_back({4'(i), fdat[i]});
            s += int'(fdat[i]);
        end
        send_byte(csum);
        if ((s + int'(csum)) % 256 == 0) set_status(1'b0, 1'b1, 1'b0);
        else                              set_status(1'b1, 1'b0, 1'b1);
    endtask

    task automatic send_bad_len(input logic [7:0] l);
        send_byte(LOADER_SYNC);
        set_status(1'b1, 1'b0, 1'b0);
        send_byte(l);
        set_status(1'b1, 1'b0, 1'b1);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fdat[i] = 8'($urandom);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        wr_q.delete();
        exp_ready = 1'b0;
        set_status(1'b1, 1'b0, 1'b0);
        idle_cycles(2);
        reset_n = 1'b1;
        idle_cycles(1);
        exp_ready = 1'b1;
    endtask

    // Stimulus: directed frames first, then randomized frames, junk and bad lengths
    initial begin : stimulus
        int          k;
        int          n;
        logic [7:0]  b;
        logic [7:0]  c;
        strm.in_valid = 1'b0;
        strm.in_data  = 8'h00;
        reset_n       = 1'b1;
        #1 reset_n    = 1'b0;
        idle_cycles(1);
        apply_reset();

        fdat[0] = 8'h05; fdat[1] = 8'h1A; fdat[2] = 8'h47;
        send_frame(3, 8'h9A);
        send_frame(3, 8'h9B);

        send_bad_len(8'h00);
        send_frame(3, 8'h9A);
        send_bad_len(8'h11);
        send_frame(3, 8'h9A);

        for (int i = 0; i < 16; i++) fdat[i] = 8'(i);
        send_frame(16, 8'h88);

        send_byte(8'h33);
        fdat[0] = 8'h80;
        send_frame(1, 8'h80);

        fdat[0] = 8'h11; fdat[1] = 8'h22; fdat[2] = 8'h33;
        send_byte(LOADER_SYNC);
        set_status(1'b1, 1'b0, 1'b0);
        send_byte(8'h03);
        send_byte(fdat[0]);
        wr_q.push_back({4'd0, fdat[0]});
        send_byte(fdat[1]);
        wr_q.push_back({4'd1, fdat[1]});
        apply_reset();
        send_frame(3, good_csum(3));

        for (int it = 0; it < 60; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 1) begin
                b = 8'($urandom);
                if (b == LOADER_SYNC) b = 8'h5A;
                send_byte(b);
            end else if (k == 2) begin
                b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255));
                send_bad_len(b);
            end else begin
                n = $urandom_range(1, 16);
                fill_random(n);
                c = good_csum(n);
                if (k == 9) c = c ^ 8'(1 << $urandom_range(0, 7));
                send_frame(n, c);
            end
        end

        idle_cycles(3);
        finish_req = 1'b1;
        #100;
        $display("FAIL watchdog: got no summary, want monitor to finish");
        $fatal(1);
    end

endmodule
